// File: rtl/mult_div_control.sv
// mult_div_control: iterative HI/LO multiply/divide unit with MIPS-style mfhi/mthi/mflo/mtlo handling.
// Latency: NB_DATA+2 cycles from accept edge to o_done (divide-by-zero: 2 cycles); mthi/mtlo write at the next edge.
// Backpressure: o_stall freezes the upstream pipeline while busy and a HI/LO-related function is presented.
// Ports: i_clk, i_reset (async active-high); i_valid/i_inst_funcion/i_dato_a/i_dato_b in;
//        o_stall, o_busy, o_done, o_hi, o_lo out.
// Option: define MULT_DIV_SIGNED_EN for signed mult/div; otherwise mult/div behave as multu/divu.

module mult_div_control #(
    parameter int NB_DATA        = 32,
    parameter int NB_INSTRUCCION = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [NB_INSTRUCCION-1:0] i_inst_funcion,
    input  logic [NB_DATA-1:0]        i_dato_a,
    input  logic [NB_DATA-1:0]        i_dato_b,
    output logic                      o_stall,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [NB_DATA-1:0]        o_hi,
    output logic [NB_DATA-1:0]        o_lo
);

    localparam int CW = $clog2(NB_DATA);

    localparam logic [NB_INSTRUCCION-1:0] F_MFHI  = NB_INSTRUCCION'(6'b010000);
    localparam logic [NB_INSTRUCCION-1:0] F_MTHI  = NB_INSTRUCCION'(6'b010001);
    localparam logic [NB_INSTRUCCION-1:0] F_MFLO  = NB_INSTRUCCION'(6'b010010);
    localparam logic [NB_INSTRUCCION-1:0] F_MTLO  = NB_INSTRUCCION'(6'b010011);
    localparam logic [NB_INSTRUCCION-1:0] F_MULT  = NB_INSTRUCCION'(6'b011000);
    localparam logic [NB_INSTRUCCION-1:0] F_MULTU = NB_INSTRUCCION'(6'b011001);
    localparam logic [NB_INSTRUCCION-1:0] F_DIV   = NB_INSTRUCCION'(6'b011010);
    localparam logic [NB_INSTRUCCION-1:0] F_DIVU  = NB_INSTRUCCION'(6'b011011);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // acc_hi: running product high half / partial remainder (holds dividend on divide-by-zero)
    // acc_lo: multiplier shifting out, product low half shifting in / dividend shifting out, quotient in
    logic [NB_DATA-1:0]   acc_hi_q, acc_hi_d;
    logic [NB_DATA-1:0]   acc_lo_q, acc_lo_d;
    logic [NB_DATA-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 div0_q, div0_d;
    logic [NB_DATA-1:0]   hi_q, hi_d;
    logic [NB_DATA-1:0]   lo_q, lo_d;

    // Function decode
    logic is_mul, is_div, is_mthi, is_mtlo, is_decoded;
    assign is_mul     = (i_inst_funcion == F_MULT) || (i_inst_funcion == F_MULTU);
    assign is_div     = (i_inst_funcion == F_DIV)  || (i_inst_funcion == F_DIVU);
    assign is_mthi    = (i_inst_funcion == F_MTHI);
    assign is_mtlo    = (i_inst_funcion == F_MTLO);
    assign is_decoded = is_mul || is_div || is_mthi || is_mtlo ||
                        (i_inst_funcion == F_MFHI) || (i_inst_funcion == F_MFLO);

    // Operand magnitudes fed to the unsigned iterative core
    logic [NB_DATA-1:0] a_mag, b_mag;
`ifdef MULT_DIV_SIGNED_EN
    logic neg_res_q, neg_res_d;   // product / quotient must be negated
    logic neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic sgn_op, a_neg, b_neg;
    assign sgn_op = (i_inst_funcion == F_MULT) || (i_inst_funcion == F_DIV);
    assign a_neg  = sgn_op && i_dato_a[NB_DATA-1];
    assign b_neg  = sgn_op && i_dato_b[NB_DATA-1];
    assign a_mag  = a_neg ? -i_dato_a : i_dato_a;
    assign b_mag  = b_neg ? -i_dato_b : i_dato_b;
`else
    assign a_mag  = i_dato_a;
    assign b_mag  = i_dato_b;
`endif

    // One iteration step of each algorithm
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA:0]     div_shift;
    logic [NB_DATA:0]     div_diff;
    logic [2*NB_DATA-1:0] product;
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[NB_DATA-1]};
    // MSB set means the trial subtraction borrowed (shifted remainder < divisor)
    assign div_diff  = div_shift - {1'b0, opb_q};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULT_DIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULT_DIV_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        product  = {acc_hi_q, acc_lo_q};
`ifdef MULT_DIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (i_valid && (is_mul || is_div)) begin
                    is_div_d = is_div;
                    cnt_d    = CW'(NB_DATA - 1);
                    div0_d   = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`endif
                    if (is_div && (i_dato_b == '0)) begin
                        // Skip iteration; SIGN publishes the fixed divide-by-zero result.
                        div0_d   = 1'b1;
                        acc_hi_d = i_dato_a;
                        state_d  = S_SIGN;
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = is_mul ? b_mag : a_mag;
                        opb_d    = is_mul ? a_mag : b_mag;
                        state_d  = S_CALC;
                    end
                end else if (i_valid && is_mthi) begin
                    hi_d = i_dato_a;
                end else if (i_valid && is_mtlo) begin
                    lo_d = i_dato_a;
                end
            end

            S_CALC: begin
                if (is_div_q) begin
                    if (!div_diff[NB_DATA]) begin
                        acc_hi_d = div_diff[NB_DATA-1:0];
                        acc_lo_d = {acc_lo_q[NB_DATA-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[NB_DATA-1:0];
                        acc_lo_d = {acc_lo_q[NB_DATA-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add: carry of the add becomes the new top bit of the product.
                    acc_hi_d = mul_sum[NB_DATA:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[NB_DATA-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = S_SIGN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_SIGN: begin
                state_d = S_DONE;
                if (div0_q) begin
                    hi_d = acc_hi_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    lo_d = acc_lo_q;
                    hi_d = acc_hi_q;
`ifdef MULT_DIV_SIGNED_EN
                    if (neg_res_q) lo_d = -acc_lo_q;
                    if (neg_rem_q) hi_d = -acc_hi_q;
`endif
                end else begin
`ifdef MULT_DIV_SIGNED_EN
                    if (neg_res_q) product = -{acc_hi_q, acc_lo_q};
`endif
                    hi_d = product[2*NB_DATA-1:NB_DATA];
                    lo_d = product[NB_DATA-1:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy  = (state_q == S_CALC) || (state_q == S_SIGN);
    assign o_done  = (state_q == S_DONE);
    assign o_stall = o_busy && i_valid && is_decoded;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule

// File: tb/tb_mult_div_control.sv
module tb_mult_div_control;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef MULT_DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [5:0]  i_func;
    logic [31:0] i_a, i_b;
    logic        o_stall, o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    mult_div_control #(.NB_DATA(32), .NB_INSTRUCCION(6)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_valid        (i_valid),
        .i_inst_funcion (i_func),
        .i_dato_a       (i_a),
        .i_dato_b       (i_b),
        .o_stall        (o_stall),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_hi           (o_hi),
        .o_lo           (o_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit decoded(input logic [5:0] f);
        return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    // Reference: HI/LO pair from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        bit     sg;
        sg = SGN && (f == F_MULT || f == F_DIV);
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if (f == F_MULT || f == F_MULTU) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (cyc=%0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", {32'b0, o_hi}, {32'b0, mon_e.hi});
                check("result_lo", {32'b0, o_lo}, {32'b0, mon_e.lo});
                check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            end
        end
    end

    // Drive one op (DUT must be IDLE or DONE now, at negedge+1) and play the
    // busy window. mode 0: random interfering functions while busy;
    // mode 1: mflo held from 3 cycles after accept through DONE.
    // Returns at negedge+1 of the expected DONE cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int mode);
        int   k, lat;
        exp_t e;
        bit   exp_stall;
        k   = cyc;
        lat = ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 2 : 34;
        e.hi = eh;
        e.lo = el;
        e.done_cyc = k + lat;
        sb_q.push_back(e);
        model_hi = eh;
        model_lo = el;
        i_valid = 1'b1; i_func = f; i_a = a; i_b = b;
        #1;
        check("stall_on_accept", {63'b0, o_stall}, 64'd0);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk); #1;
            if (n < lat) begin
                if (mode == 1) begin
                    i_valid = (n >= 3);
                    i_func  = F_MFLO;
                end else begin
                    i_valid = ($urandom_range(0, 1) == 1);
                    case ($urandom_range(0, 3))
                        0:       i_func = F_MTHI;
                        1:       i_func = F_MTLO;
                        2:       i_func = 6'($urandom_range(0, 63));
                        default: i_func = 6'($urandom_range(16, 27));
                    endcase
                    i_a = $urandom();
                    i_b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom();
                end
                exp_stall = i_valid && decoded(i_func);
                #1;
                check("stall_busy", {63'b0, o_stall}, {63'b0, exp_stall});
            end else begin
                if (mode == 1) begin
                    i_valid = 1'b1;
                    i_func  = F_MFLO;
                    #1;
                    check("stall_in_done", {63'b0, o_stall}, 64'd0);
                    check("busy_in_done", {63'b0, o_busy}, 64'd0);
                end else begin
                    i_valid = 1'b0;
                    i_func  = 6'd0;
                end
            end
        end
    endtask

    task automatic run_rand(input int mode);
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0:       f = F_MULT;
            1:       f = F_MULTU;
            2:       f = F_DIV;
            default: f = F_DIVU;
        endcase
        a = $urandom();
        b = $urandom();
        case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: a = 32'hFFFF_FFFF;
            3: a = 32'($urandom_range(0, 100));
            default: ;
        endcase
        r = model(f, a, b);
        run_op(f, a, b, r[63:32], r[31:0], mode);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_func  = 6'd0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a);
        i_valid = 1'b1; i_func = f; i_a = a; i_b = $urandom();
        #1;
        check("stall_mt_idle", {63'b0, o_stall}, 64'd0);
        @(negedge clk); #1;
        i_valid = 1'b0;
        if (f == F_MTHI) model_hi = a;
        if (f == F_MTLO) model_lo = a;
        check("mt_hi", {32'b0, o_hi}, {32'b0, model_hi});
        check("mt_lo", {32'b0, o_lo}, {32'b0, model_lo});
        check("mt_no_done", {63'b0, o_done}, 64'd0);
        check("mt_no_busy", {63'b0, o_busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_func = 6'd0; i_a = '0; i_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", {32'b0, o_hi}, 64'd0);
        check("rst_lo", {32'b0, o_lo}, 64'd0);
        check("rst_busy_done", {62'b0, o_busy, o_done}, 64'd0);
        rst = 1'b0;

        // First op accepted on the first edge after reset release.
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
`ifdef MULT_DIV_SIGNED_EN
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
`else
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 0);
`endif
        run_op(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        idle(2);
        run_op(F_MULT, 32'd1234, 32'd5678, 32'd0, 32'd7006652, 1);
        idle(1);
        move_to(F_MTHI, 32'hDEAD_BEEF);
        move_to(F_MTLO, 32'h1234_5678);
        move_to(F_MFHI, 32'hAAAA_5555);

        for (int i = 0; i < 16; i++) begin
            run_rand(($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // Reset in the middle of CALC discards the operation.
        idle(1);
        i_valid = 1'b1; i_func = F_MULTU; i_a = $urandom(); i_b = $urandom();
        @(negedge clk); #1;
        i_valid = 1'b0;
        repeat (9) begin
            @(negedge clk); #1;
        end
        check("busy_before_reset", {63'b0, o_busy}, 64'd1);
        i_valid = 1'b1; i_func = F_MULT;
        rst = 1'b1;
        #1;
        check("midrst_hi", {32'b0, o_hi}, 64'd0);
        check("midrst_lo", {32'b0, o_lo}, 64'd0);
        check("midrst_ctl", {61'b0, o_busy, o_stall, o_done}, 64'd0);
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk); #1;
        i_valid = 1'b0;
        rst = 1'b0;
        run_op(F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);
        idle(3);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_control.md
MULT_DIV_CONTROL -- requirements
Module: mult_div_control

Interface
REQ-001 Parameter NB_DATA, default 32, operand/HI/LO width.
REQ-002 Parameter NB_INSTRUCCION, default 6, function-field width.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  instruction in EX is an R-type whose function field is presented this cycle.
REQ-006 i_inst_funcion  input  NB_INSTRUCCION  R-type function field.
REQ-007 i_dato_a  input  NB_DATA  rs operand (multiplicand/dividend, mthi/mtlo source).
REQ-008 i_dato_b  input  NB_DATA  rt operand (multiplier/divisor).
REQ-009 o_stall  output  1  freeze upstream pipeline this cycle.
REQ-010 o_busy  output  1  iterative operation in progress.
REQ-011 o_done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 o_hi, o_lo  output  NB_DATA each  architectural HI/LO registers (mfhi/mflo read data).

Function
REQ-013 Decoded functions: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; all others ignored.
REQ-014 States: IDLE, CALC, SIGN, DONE; o_busy = 1 in CALC and SIGN only.
REQ-015 IDLE or DONE with i_valid and mult/multu/div/divu: latch operands (magnitudes for signed ops), iteration counter = NB_DATA-1, go CALC.
REQ-016 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; at counter 0 go SIGN.
REQ-017 SIGN: apply two's-complement correction (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); write HI/LO; go DONE.
REQ-018 Unsigned ops pass through SIGN with no correction; result latency fixed at NB_DATA+2 cycles from accept edge to o_done high.
REQ-019 Multiply result: HI = product[2*NB_DATA-1:NB_DATA], LO = product[NB_DATA-1:0].
REQ-020 Divide result: LO = quotient, HI = remainder.
REQ-021 Divide by zero: no CALC; go DONE next cycle with LO = all ones, HI = i_dato_a.
REQ-022 Signed div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, normal latency.
REQ-023 DONE: o_done = 1 for exactly one cycle, then IDLE unless a new op is accepted (REQ-015).
REQ-024 mthi/mtlo in IDLE or DONE: HI/LO written at next edge; no busy, no o_done.
REQ-025 o_stall = o_busy AND i_valid AND function in REQ-013 set; otherwise 0.
REQ-026 While busy, no decoded function alters state, operands, HI or LO.
REQ-027 HI/LO never change except at REQ-017, REQ-021, REQ-024 edges.

Reset
REQ-028 Reset asserted (any time, including mid-CALC): state IDLE, counter 0, HI = LO = 0, o_busy = o_stall = o_done = 0; in-flight operation discarded.
REQ-029 First op is accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro MULT_DIV_SIGNED_EN defined: mult/div signed per REQ-017/REQ-022.
REQ-031 Macro MULT_DIV_SIGNED_EN undefined: mult/div behave exactly as multu/divu; no sign logic synthesized; latency unchanged.

Verification
REQ-032 multu 0xFFFFFFFF x 0xFFFFFFFF -> o_done 34 cycles after accept; HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-033 div -7 / 2 (macro defined) -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; macro undefined -> LO = 0x7FFFFFFC, HI = 0x00000001.
REQ-034 divu 5 / 0 -> o_done 2 cycles after accept, LO = 0xFFFFFFFF, HI = 5.
REQ-035 mflo issued 3 cycles after mult accept -> o_stall high until SIGN ends, 0 in DONE; o_lo correct in DONE.
REQ-036 Reset pulsed at CALC cycle 10 -> outputs cleared immediately; next multu 3 x 4 yields LO = 12, HI = 0.
